// File: rtl/button_poll_master_if.sv
// Bundles the Avalon-MM read port and the event stream of button_poll_master.
// Master is the poller side; slave is the PIO plus the event consumer.
interface button_poll_master_if #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 2
);
  logic [ADDR_W-1:0]   avm_address;
  logic                avm_read;
  logic                avm_waitrequest;
  logic [31:0]         avm_readdata;
  logic                avm_readdatavalid;
  logic                evt_valid;
  logic                evt_ready;
  logic [3*DATA_W-1:0] evt_data;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata,
    input  avm_readdatavalid,
    output evt_valid,
    input  evt_ready,
    output evt_data
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata,
    output avm_readdatavalid,
    input  evt_valid,
    output evt_ready,
    input  evt_data
  );
endinterface

// File: rtl/button_poll_master.sv
// Periodically reads word 0 of a button PIO over Avalon-MM, detects per-bit rising/falling
// changes between samples and queues {sample, rise, fall} events in a first-word-fall-through FIFO.
module button_poll_master #(
  parameter int unsigned DATA_W         = 4,
  parameter int unsigned ADDR_W         = 2,
  parameter int unsigned POLL_CYCLES    = 50000,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  button_poll_master_if.master bus,
  output logic [DATA_W-1:0]    cur_state_o,
  output logic                 overflow_o,
  output logic                 timeout_o,
  input  logic                 flags_clr_i
);

  localparam int unsigned PollW = $clog2(POLL_CYCLES);
  localparam int unsigned ToW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned EvtW  = 3 * DATA_W;

  localparam logic [PollW-1:0] PollMax  = PollW'(POLL_CYCLES - 1);
  localparam logic [ToW-1:0]   ToMax    = ToW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0]  FifoFull = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StCmp} state_e;

  state_e              state_q, state_d;
  logic [PollW-1:0]    poll_q, poll_d;
  logic [ToW-1:0]      wait_q, wait_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic [DATA_W-1:0]   cur_q, cur_d;
  logic                base_q, base_d;
  logic                ovf_q, ovf_d;
  logic                to_q, to_d;
  logic                poll_tick;
  logic                timeout_set;

  logic [EvtW-1:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_q, wr_d;
  logic [PtrW-1:0]     rd_q, rd_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                in_cmp;
  logic [DATA_W-1:0]   rise, fall;
  logic                push, pop, full, push_ok, drop;
  logic                unused_rdata;

  // Upper readdata bits are not part of the sampled word.
  assign unused_rdata = ^bus.avm_readdata;

  // Free-running poll timer; a tick that lands outside StIdle is simply lost.
  assign poll_tick = (poll_q == '0);
  assign poll_d    = poll_tick ? PollMax : poll_q - 1'b1;

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    sample_d    = sample_q;
    timeout_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (poll_tick) state_d = StReq;
      end
      StReq: begin
        if (!bus.avm_waitrequest) begin
          state_d = StWait;
          wait_d  = '0;
        end
      end
      StWait: begin
        if (bus.avm_readdatavalid) begin
          sample_d = bus.avm_readdata[DATA_W-1:0];
          state_d  = StCmp;
        end else if (wait_q == ToMax) begin
          state_d     = StIdle;
          timeout_set = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StCmp: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.avm_read    = (state_q == StReq);
  assign bus.avm_address = {ADDR_W{1'b0}};

  // Edge detection; the first compare after reset only establishes the baseline.
  assign in_cmp = (state_q == StCmp);
  assign rise   = sample_q & ~cur_q;
  assign fall   = ~sample_q & cur_q;
  assign cur_d  = in_cmp ? sample_q : cur_q;
  assign base_d = base_q | in_cmp;
  assign push   = in_cmp & base_q & (|(rise | fall));

  assign full    = (cnt_q == FifoFull);
  assign pop     = (cnt_q != '0) & bus.evt_ready;
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

  assign wr_d = push_ok ? wr_q + 1'b1 : wr_q;
  assign rd_d = pop ? rd_q + 1'b1 : rd_q;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // A set in the same cycle as flags_clr keeps the flag high.
  assign ovf_d = drop | (ovf_q & ~flags_clr_i);
  assign to_d  = timeout_set | (to_q & ~flags_clr_i);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      poll_q   <= PollMax;
      wait_q   <= '0;
      sample_q <= '0;
      cur_q    <= '0;
      base_q   <= 1'b0;
      ovf_q    <= 1'b0;
      to_q     <= 1'b0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      poll_q   <= poll_d;
      wait_q   <= wait_d;
      sample_q <= sample_d;
      cur_q    <= cur_d;
      base_q   <= base_d;
      ovf_q    <= ovf_d;
      to_q     <= to_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: the output is gated by the occupancy count.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= {sample_q, rise, fall};
  end

  assign bus.evt_valid = (cnt_q != '0);
  assign bus.evt_data  = bus.evt_valid ? mem_q[rd_q] : '0;
  assign cur_state_o   = cur_q;
  assign overflow_o    = ovf_q;
  assign timeout_o     = to_q;

endmodule

// File: tb/tb_button_poll_master.sv
// Directed and randomized bench for button_poll_master; a queue-based event model supplies
// every expected value.
module tb_button_poll_master;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned POLL   = 8;
  localparam int unsigned TO     = 16;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              flags_clr;
  logic [DATA_W-1:0] cur_state;
  logic              overflow;
  logic              timeout;

  button_poll_master_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  button_poll_master #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .POLL_CYCLES(POLL),
    .TIMEOUT_CYCLES(TO),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk),
    .reset_i(reset),
    .bus(bus),
    .cur_state_o(cur_state),
    .overflow_o(overflow),
    .timeout_o(timeout),
    .flags_clr_i(flags_clr)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model
  logic [3:0]  m_cur;
  bit          m_base;
  bit          m_ov;
  bit          m_to;
  logic [11:0] m_q[$];

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned read_cyc;
  int unsigned prev_cyc;
  int unsigned rel_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic check_outputs(input string tag);
    logic [11:0] head;
    head = (m_q.size() != 0) ? m_q[0] : 12'h000;
    chk({tag, ":evt_valid"}, bus.evt_valid, m_q.size() != 0);
    chk({tag, ":evt_data"}, bus.evt_data, head);
    chk({tag, ":cur_state"}, cur_state, m_cur);
    chk({tag, ":overflow"}, overflow, m_ov);
    chk({tag, ":timeout"}, timeout, m_to);
  endtask

  task automatic model_reset();
    m_cur  = 4'h0;
    m_base = 1'b0;
    m_ov   = 1'b0;
    m_to   = 1'b0;
    m_q.delete();
  endtask

  // Applies one accepted sample to the model, bit by bit.
  task automatic model_sample(input logic [3:0] d);
    logic [3:0] rise, fall;
    rise = 4'h0;
    fall = 4'h0;
    for (int b = 0; b < 4; b++) begin
      if (d[b] && !m_cur[b]) rise[b] = 1'b1;
      if (!d[b] && m_cur[b]) fall[b] = 1'b1;
    end
    if (!m_base) m_base = 1'b1;
    else if (rise != 4'h0 || fall != 4'h0) begin
      if (m_q.size() == DEPTH) m_ov = 1'b1;
      else m_q.push_back({d, rise, fall});
    end
    m_cur = d;
  endtask

  task automatic wait_read(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.avm_read === 1'b1) begin
        ok       = 1'b1;
        read_cyc = cyc;
        return;
      end
      @(negedge clk);
    end
    chk("read_seen", bus.avm_read, 1);
  endtask

  // Accepts a read after `stall` waitrequest cycles (returns 0 on timeout).
  task automatic accept_read(input int stall, output bit ok);
    wait_read(ok);
    if (!ok) return;
    chk("addr", bus.avm_address, 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("read_held", bus.avm_read, 1);
      chk("addr_held", bus.avm_address, 0);
    end
    bus.avm_waitrequest = 1'b0;
    @(negedge clk);
    bus.avm_waitrequest = 1'b1;
    chk("read_drop", bus.avm_read, 0);
  endtask

  task automatic txn(input logic [3:0] d, input int stall, input int lat);
    bit ok;
    logic [31:0] rd;
    accept_read(stall, ok);
    if (!ok) return;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      chk("one_read", bus.avm_read, 0);
    end
    rd = $urandom;
    rd[3:0] = d;
    bus.avm_readdatavalid = 1'b1;
    bus.avm_readdata      = rd;
    @(negedge clk);
    bus.avm_readdatavalid = 1'b0;
    bus.avm_readdata      = $urandom;
    chk("lat1_valid", bus.evt_valid, m_q.size() != 0);
    chk("lat1_cur", cur_state, m_cur);
    @(negedge clk);
    model_sample(d);
    check_outputs("cmp");
  endtask

  task automatic stray_rdv();
    bus.avm_readdatavalid = 1'b1;
    bus.avm_readdata      = {28'h0, ~m_cur};
    @(negedge clk);
    bus.avm_readdatavalid = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs("stray");
  endtask

  task automatic pop_one();
    if (m_q.size() != 0) chk("pop_head", bus.evt_data, m_q[0]);
    bus.evt_ready = 1'b1;
    @(negedge clk);
    bus.evt_ready = 1'b0;
    if (m_q.size() != 0) void'(m_q.pop_front());
    check_outputs("pop");
  endtask

  task automatic clear_flags();
    flags_clr = 1'b1;
    @(negedge clk);
    flags_clr = 1'b0;
    m_ov = 1'b0;
    m_to = 1'b0;
    check_outputs("clr");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish required finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    logic [3:0] d;
    reset                 = 1'b1;
    flags_clr             = 1'b0;
    bus.avm_waitrequest   = 1'b1;
    bus.avm_readdata      = 32'h0;
    bus.avm_readdatavalid = 1'b0;
    bus.evt_ready         = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs("reset");
    chk("reset:read", bus.avm_read, 0);
    chk("reset:addr", bus.avm_address, 0);
    reset   = 1'b0;
    rel_cyc = cyc;

    // Baseline, then poll period
    txn(4'h0, 0, 0);
    chk("first_poll", read_cyc - rel_cyc, POLL);
    prev_cyc = read_cyc;
    txn(4'h0, 0, 0);
    chk("poll_period", read_cyc - prev_cyc, POLL);

    // Directed edges
    txn(4'h5, 0, 1);
    chk("dir_evt_a", bus.evt_data, 12'h550);
    txn(4'h1, 0, 2);
    pop_one();
    chk("dir_evt_b", bus.evt_data, 12'h104);
    pop_one();
    pop_one();

    // Long stall: read held for 6 cycles
    txn(4'h9, 5, 0);
    stray_rdv();

    // Random traffic
    for (int i = 0; i < 24; i++) begin
      d = 4'($urandom_range(0, 15));
      txn(d, $urandom_range(0, 3), $urandom_range(0, 8));
      if ($urandom_range(0, 1) == 1) pop_one();
      if ($urandom_range(0, 3) == 0) stray_rdv();
    end
    while (m_q.size() != 0) pop_one();
    clear_flags();

    // Overflow with full FIFO, order preserved
    for (int i = 0; i < 5; i++) txn(~m_cur, $urandom_range(0, 2), $urandom_range(0, 4));
    chk("ovf_set", overflow, 1);
    for (int i = 0; i < DEPTH; i++) pop_one();
    chk("ovf_drained", bus.evt_valid, 0);

    // Timeout; flags_clr coinciding with the set loses
    accept_read(0, ok);
    if (ok) begin
      for (int j = 0; j < TO; j++) begin
        chk("to_pending", timeout, 0);
        chk("to_read", bus.avm_read, 0);
        if (j == TO - 1) flags_clr = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;
      end
      m_to = 1'b1;
      m_ov = 1'b0;
      check_outputs("timeout");
      stray_rdv();
      clear_flags();
    end

    // Reset during WAIT with FIFO holding entries
    txn(~m_cur, 0, 0);
    txn(~m_cur, 0, 0);
    accept_read(1, ok);
    if (ok) begin
      reset = 1'b1;
      @(negedge clk);
      reset                 = 1'b0;
      rel_cyc               = cyc;
      bus.avm_readdatavalid = 1'b1;
      bus.avm_readdata      = 32'hFFFF_FFFF;
      @(negedge clk);
      bus.avm_readdatavalid = 1'b0;
      model_reset();
      check_outputs("mid_reset");
      chk("mid_reset:read", bus.avm_read, 0);
      txn(4'h3, 0, 0);
      chk("reset_poll", read_cyc - rel_cyc, POLL);
      check_outputs("rebase");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
